// File: rtl/uart_crc_pkg.sv
// Shared definitions for the UART CRC packet reader and writer: state encoding,
// CRC-8 defaults and the bitwise CRC-8 update.
package uart_crc_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_CRC     = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_PAYLOAD = S_PAYLOAD,
    ST_CRC     = S_CRC,
    ST_DRAIN   = S_DRAIN
  } state_t;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  // MSB-first, unreflected, no final xor
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? poly : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_byte.sv
// Combinational CRC-8 update of one byte; shared by the RX framer and the TX writer.
module crc8_byte
  import uart_crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  assign crc_o = crc8_step(crc_i, data_i, POLY);

endmodule

// File: rtl/uart_crc_rx_framer.sv
// Collects [LEN][PAYLOAD][CRC8] frames from UART_RX and releases the payload only on good CRC.
// Optional inter-byte timeout is compiled in with UART_RX_TIMEOUT_EN.
module uart_crc_rx_framer
  import uart_crc_pkg::*;
#(
  parameter int         MAX_LEN    = 16,
  parameter logic [7:0] CRC_POLY   = CRC8_POLY_DEFAULT,
  parameter logic [7:0] CRC_INIT   = CRC8_INIT_DEFAULT,
  parameter int         TIMEOUT_CY = 2048
) (
  input  logic       clk_master,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       data_ready_i,
  output logic       data_last_o,
  output logic       pkt_done_o,
  output logic       crc_ok_o,
  output logic       crc_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_q, last_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    buf_q [MAX_LEN];
  logic [7:0]    buf_d [MAX_LEN];
  logic          pkt_done_q, pkt_done_d;
  logic          crc_ok_q, crc_ok_d;
  logic          crc_err_q, crc_err_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic [7:0]    crc_base;
  logic [7:0]    crc_next;
  logic          len_ok;
  logic          at_last;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CY + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_expire;
  assign tmo_expire = (tmo_q == TW'(TIMEOUT_CY - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CY;
`endif

  assign crc_base = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

  crc8_byte #(.POLY(CRC_POLY)) u_crc8 (
    .crc_i  (crc_base),
    .data_i (rx_data_i),
    .crc_o  (crc_next)
  );

  assign len_ok  = (rx_data_i != 8'h00) && (int'(rx_data_i) <= MAX_LEN);
  assign at_last = (cnt_q == last_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    crc_d       = crc_q;
    buf_d       = buf_q;
    pkt_done_d  = 1'b0;
    crc_ok_d    = 1'b0;
    crc_err_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
    tmo_d       = '0;
`endif

    if (!en_i) begin
      // Silent abort; a strobe in this cycle is ignored as well.
      state_d = ST_IDLE;
      cnt_d   = '0;
      crc_d   = CRC_INIT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_done_i) begin
            if (len_ok) begin
              last_d  = CW'(rx_data_i - 8'd1);
              cnt_d   = '0;
              crc_d   = crc_next;
              state_d = ST_PAYLOAD;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_done_i) begin
            buf_d[cnt_q] = rx_data_i;
            crc_d        = crc_next;
            if (at_last) begin
              state_d = ST_CRC;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_CRC: begin
          if (rx_done_i) begin
            pkt_done_d = 1'b1;
            cnt_d      = '0;
            crc_d      = CRC_INIT;
            if (rx_data_i == crc_q) begin
              crc_ok_d = 1'b1;
              state_d  = ST_DRAIN;
            end else begin
              crc_err_d = 1'b1;
              state_d   = ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          overrun_d = rx_done_i;
          if (data_ready_i) begin
            if (at_last) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      endcase

`ifdef UART_RX_TIMEOUT_EN
      // Counts idle cycles between strobes while a frame is being received.
      if ((state_q == ST_PAYLOAD || state_q == ST_CRC) && !rx_done_i) begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_expire) begin
          tmo_d       = '0;
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
          crc_d       = CRC_INIT;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_master or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      crc_q       <= CRC_INIT;
      pkt_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= 8'h00;
      end
`ifdef UART_RX_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      crc_q       <= crc_d;
      pkt_done_q  <= pkt_done_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      buf_q       <= buf_d;
`ifdef UART_RX_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign data_valid_o = (state_q == ST_DRAIN);
  assign data_o       = data_valid_o ? buf_q[cnt_q] : 8'h00;
  assign data_last_o  = data_valid_o && at_last;
  assign pkt_done_o   = pkt_done_q;
  assign crc_ok_o     = crc_ok_q;
  assign crc_err_o    = crc_err_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_crc_rx_framer.sv
// Bench for uart_crc_rx_framer: table-driven frames, hand-written corner sequences and random frames
// checked against a polynomial-division CRC model and a drained-byte scoreboard.
module tb_uart_crc_rx_framer;

  localparam int MAXL = 16;
  localparam int TMO  = 64;

  logic       clk_master = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b1;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_done_i = 1'b0;
  logic       data_ready_i;
  logic [7:0] data_o;
  logic       data_valid_o, data_last_o, pkt_done_o, crc_ok_o, crc_err_o;
  logic       frame_err_o, overrun_o, busy_o;

  uart_crc_rx_framer #(.MAX_LEN(MAXL), .TIMEOUT_CY(TMO)) dut (
    .clk_master   (clk_master),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .rx_data_i    (rx_data_i),
    .rx_done_i    (rx_done_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_last_o  (data_last_o),
    .pkt_done_o   (pkt_done_o),
    .crc_ok_o     (crc_ok_o),
    .crc_err_o    (crc_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk_master = ~clk_master;

  int total = 0;
  int bad   = 0;

  // Downstream ready: pseudo-random or manually held.
  bit   rdy_rand = 1'b0;
  logic rdy_man  = 1'b1;
  initial begin
    data_ready_i = 1'b1;
    forever begin
      @(posedge clk_master);
      #1;
      data_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_man;
    end
  end

  // Passive monitor sampled on the falling edge.
  int         n_pkt = 0, n_ok = 0, n_err = 0, n_ferr = 0, n_ovr = 0, n_valid = 0, n_unstable = 0;
  logic [7:0] out_q[$];
  bit         last_q[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  always @(negedge clk_master) begin
    if (!rst_i) begin
      if (pkt_done_o)  n_pkt++;
      if (crc_ok_o)    n_ok++;
      if (crc_err_o)   n_err++;
      if (frame_err_o) n_ferr++;
      if (overrun_o)   n_ovr++;
      if (data_valid_o) n_valid++;
      if (prev_stall && data_valid_o && data_o !== prev_dat) n_unstable++;
      if (data_valid_o && data_ready_i) begin
        out_q.push_back(data_o);
        last_q.push_back(data_last_o);
      end
      prev_stall = data_valid_o && !data_ready_i;
      prev_dat   = data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  logic [7:0] msg_b [MAXL+1];
  logic [7:0] pay   [MAXL];

  // CRC as remainder of mod-2 long division of (message * x^8) by x^8+x^2+x+1.
  function automatic logic [7:0] model_crc(input int n);
    bit         bits[$];
    logic [8:0] g;
    logic [7:0] r;
    g = 9'h107;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) bits.push_back(msg_b[i][b]);
    repeat (8) bits.push_back(1'b0);
    for (int i = 0; i < bits.size() - 8; i++)
      if (bits[i])
        for (int j = 0; j < 9; j++) bits[i+j] = bits[i+j] ^ g[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = bits[bits.size()-8+j];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_master);
    #1;
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(posedge clk_master);
    #1;
    rx_done_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len, input int npay, input logic [7:0] crc_xor);
    msg_b[0] = len;
    send_byte(len);
    for (int i = 0; i < npay; i++) begin
      msg_b[i+1] = pay[i];
      send_byte(pay[i]);
    end
    if (npay > 0) send_byte(model_crc(npay + 1) ^ crc_xor);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      @(posedge clk_master);
      #1;
      k++;
    end
    if (busy_o) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy_o=%0b after %0d cycles, expected 0", busy_o, budget);
    end
  endtask

  task automatic check_out(input string nm, input int base, input int exp_n);
    int nbad;
    nbad = 0;
    check({nm, ".nout"}, out_q.size() - base, exp_n);
    for (int i = 0; i < exp_n && base + i < out_q.size(); i++) begin
      if (out_q[base+i] !== pay[i]) nbad++;
      if (last_q[base+i] !== (i == exp_n - 1)) nbad++;
    end
    check({nm, ".data_last"}, nbad, 0);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] len, input int npay,
                           input logic [7:0] crc_xor, input bit e_ok, input bit e_err, input bit e_ferr);
    int b_ok, b_err, b_ferr, b_pkt, b_out;
    b_ok = n_ok; b_err = n_err; b_ferr = n_ferr; b_pkt = n_pkt; b_out = out_q.size();
    send_frame(len, npay, crc_xor);
    wait_idle(600);
    @(negedge clk_master);
    @(negedge clk_master);
    check({nm, ".ok"},   n_ok - b_ok, 32'(e_ok));
    check({nm, ".err"},  n_err - b_err, 32'(e_err));
    check({nm, ".ferr"}, n_ferr - b_ferr, 32'(e_ferr));
    check({nm, ".pkt"},  n_pkt - b_pkt, 32'(e_ok) + 32'(e_err));
    check_out(nm, b_out, e_ok ? npay : 0);
  endtask

  typedef struct {
    logic [7:0] len;
    int         npay;
    logic [7:0] crc_xor;
    bit         e_ok;
    bit         e_err;
    bit         e_ferr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_out, b_val, b_ovr, b_uns, b_sum;
    tbl[0] = '{8'h00,  0, 8'h00, 0, 0, 1};
    tbl[1] = '{8'h11,  0, 8'h00, 0, 0, 1};
    tbl[2] = '{8'hFF,  0, 8'h00, 0, 0, 1};
    tbl[3] = '{8'h01,  1, 8'h00, 1, 0, 0};
    tbl[4] = '{8'h10, 16, 8'h00, 1, 0, 0};
    tbl[5] = '{8'h05,  5, 8'h01, 0, 1, 0};
    tbl[6] = '{8'h02,  2, 8'h00, 1, 0, 0};
    tbl[7] = '{8'h0A, 10, 8'h80, 0, 1, 0};

    // Reset state
    repeat (3) @(posedge clk_master);
    #1;
    check("reset.outputs", {data_o, data_valid_o, data_last_o, pkt_done_o, crc_ok_o, crc_err_o,
                            frame_err_o, overrun_o, busy_o}, 0);
    rst_i = 1'b0;
    @(posedge clk_master);
    #1;
    check("reset.busy_after", busy_o, 0);

    // Good frame 01,01,12 with downstream stalled
    rdy_man = 1'b0;
    @(posedge clk_master);
    b_out = out_q.size();
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h12);
    check("t1.pkt_done", pkt_done_o, 1);
    check("t1.crc_ok", crc_ok_o, 1);
    check("t1.crc_err", crc_err_o, 0);
    check("t1.valid", data_valid_o, 1);
    check("t1.data", data_o, 8'h01);
    check("t1.last", data_last_o, 1);
    @(posedge clk_master);
    #1;
    check("t1.pulse_width", pkt_done_o, 0);
    check("t1.held", {data_valid_o, data_o}, {1'b1, 8'h01});
    rdy_man = 1'b1;
    wait_idle(20);
    @(negedge clk_master);
    check("t1.nout", out_q.size() - b_out, 1);

    // Bad CRC 01,01,13
    b_val = n_valid;
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h13);
    check("t2.crc_err", crc_err_o, 1);
    check("t2.pkt_done", pkt_done_o, 1);
    check("t2.crc_ok", crc_ok_o, 0);
    repeat (3) @(posedge clk_master);
    @(negedge clk_master);
    check("t2.never_valid", n_valid - b_val, 0);
    check("t2.busy", busy_o, 0);

    // Table of frames with random payload and random backpressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < MAXL; i++) pay[i] = 8'($urandom);
      run_frame($sformatf("tbl%0d", t), tbl[t].len, tbl[t].npay, tbl[t].crc_xor,
                tbl[t].e_ok, tbl[t].e_err, tbl[t].e_ferr);
    end
    pay[0] = 8'h01;
    run_frame("t3.after_len_err", 8'h01, 1, 8'h00, 1, 0, 0);

    // Backpressure with overrun injected during drain
    rdy_rand = 1'b0;
    rdy_man  = 1'b0;
    for (int i = 0; i < MAXL; i++) pay[i] = 8'($urandom);
    b_out = out_q.size(); b_ovr = n_ovr; b_uns = n_unstable;
    send_frame(8'(MAXL), MAXL, 8'h00);
    check("t4.valid", data_valid_o, 1);
    repeat (2) @(posedge clk_master);
    send_byte(8'hA5);
    check("t4.overrun", overrun_o, 1);
    check("t4.still_first", {data_valid_o, data_o}, {1'b1, pay[0]});
    rdy_rand = 1'b1;
    wait_idle(600);
    @(negedge clk_master);
    @(negedge clk_master);
    check_out("t4", b_out, MAXL);
    check("t4.stable", n_unstable - b_uns, 0);
    check("t4.n_ovr", n_ovr - b_ovr, 1);

    // Abort by reset, then by en_i low with a simultaneous strobe
    b_sum = n_pkt + n_ok + n_err + n_ferr + n_ovr; b_val = n_valid;
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    check("t5.busy_mid", busy_o, 1);
    @(posedge clk_master);
    #1;
    rst_i = 1'b1;
    #1;
    check("t5.rst_busy", busy_o, 0);
    @(posedge clk_master);
    #1;
    rst_i = 1'b0;
    send_byte(8'h03); send_byte(8'h33); send_byte(8'h44);
    @(posedge clk_master);
    #1;
    en_i = 1'b0; rx_data_i = 8'h01; rx_done_i = 1'b1;
    @(posedge clk_master);
    #1;
    en_i = 1'b1; rx_done_i = 1'b0;
    check("t5.en_busy", busy_o, 0);
    repeat (4) @(posedge clk_master);
    @(negedge clk_master);
    check("t5.no_pulses", n_pkt + n_ok + n_err + n_ferr + n_ovr - b_sum, 0);
    check("t5.no_valid", n_valid - b_val, 0);
    pay[0] = 8'h01;
    run_frame("t5.next", 8'h01, 1, 8'h00, 1, 0, 0);

    // Random frames against the model
    for (int f = 0; f < 20; f++) begin
      int         r, n;
      logic [7:0] len, cx;
      r = $urandom_range(0, 9);
      for (int i = 0; i < MAXL; i++) pay[i] = 8'($urandom);
      if (r == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
        run_frame($sformatf("rnd%0d", f), len, 0, 8'h00, 0, 0, 1);
      end else begin
        n  = $urandom_range(1, MAXL);
        cx = (r < 3) ? 8'($urandom_range(1, 255)) : 8'h00;
        run_frame($sformatf("rnd%0d", f), 8'(n), n, cx, cx == 8'h00, cx != 8'h00, 0);
      end
    end

`ifdef UART_RX_TIMEOUT_EN
    begin
      int early;
      early = 0;
      send_byte(8'h03); send_byte(8'h5A);
      repeat (TMO - 1) begin
        @(posedge clk_master);
        #1;
        if (frame_err_o) early++;
      end
      check("t6.early", early, 0);
      @(posedge clk_master);
      #1;
      check("t6.frame_err", frame_err_o, 1);
      check("t6.busy", busy_o, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
